stream_serializer: RTL

- Single-clock wide-to-narrow width converter that sits directly downstream of the gray-code CDC FIFO destination port.
- Takes one wide word of RATIO*NARROW_W bits per valid/ready handshake.
- Emits RATIO narrow beats on a valid/ready stream and flags the final beat with last.
- Lets the CDC FIFO carry full-width words at low rate while the destination logic consumes narrow beats at full rate.

---
 rtl/stream_serializer_pkg.sv | 18 +
 rtl/serializer_beat_cnt.sv | 49 ++++
 rtl/stream_serializer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stream_serializer_pkg.sv
// Shared types and helpers for the wide-to-narrow stream serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Beat counter width; a 1-bit floor keeps the counter legal for tiny ratios.
    function automatic int cnt_width(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serializer_beat_cnt.sv
// Mod-RATIO beat counter with synchronous clear, count enable and at_last flag.
// Latency: count updates one cycle after clr_i/en_i; at_last_o is combinational from the count.
// Backpressure: holds its value whenever en_i and clr_i are both low.
module serializer_beat_cnt
    import stream_serializer_pkg::*;
#(
    parameter  int RATIO = 4,
    localparam int CW    = cnt_width(RATIO)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          at_last_o
);

    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    assign cnt_o     = cnt_q;
    assign at_last_o = (cnt_q == LAST_CNT);

    // Next count: clear wins; wrap explicitly at RATIO-1 so unused codes are never visited.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last_o ? '0 : (cnt_q + CW'(1));
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter must never leave the 0..RATIO-1 range.
    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= LAST_CNT)
        else $error("serializer_beat_cnt: count out of range");

endmodule

// File: rtl/stream_serializer.sv
// Wide-to-narrow serializer: one WIDE_W word in, RATIO NARROW_W beats out, last on the final beat.
// Latency: first beat one cycle after word acceptance; back-to-back words with no bubble.
// Backpressure: beat held stable while narrow_ready_i low; wide_ready_o only when idle or on the last-beat handshake.
// Build option STREAM_SERIALIZER_MSB_FIRST_EN: emit most-significant slice first (default LSB first).
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter  int NARROW_W = 8,
    parameter  int RATIO    = 4,
    localparam int WIDE_W   = NARROW_W * RATIO,
    localparam int CW       = cnt_width(RATIO)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [WIDE_W-1:0]   wide_data_i,
    input  logic                wide_valid_i,
    output logic                wide_ready_o,
    output logic [NARROW_W-1:0] narrow_data_o,
    output logic                narrow_valid_o,
    output logic                narrow_last_o,
    input  logic                narrow_ready_i,
    output logic                busy_o
);

    ser_state_e        state_d;
    ser_state_e        state_q;
    logic [WIDE_W-1:0] buf_d;
    logic [WIDE_W-1:0] buf_q;

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     sel;
    logic              at_last;
    logic              busy;
    logic              beat_hs;
    logic              last_hs;
    logic              accept;

    assign busy           = (state_q == SHIFT);
    assign busy_o         = busy;
    assign narrow_valid_o = busy;
    assign narrow_last_o  = busy & at_last;

    assign beat_hs = narrow_valid_o & narrow_ready_i;
    assign last_hs = beat_hs & narrow_last_o;

    // Ready during the last-beat handshake lets the next word load with no bubble.
    assign wide_ready_o = ~busy | last_hs;
    assign accept       = wide_valid_i & wide_ready_o;

    // Next state and buffer load: a word is taken from IDLE or on the last-beat handshake.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_hs) begin
                    state_d = wide_valid_i ? SHIFT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            buf_d = wide_data_i;
        end
    end

    // State and holding-buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    // Loading a word and finishing a word both restart at beat 0.
    serializer_beat_cnt #(
        .RATIO (RATIO)
    ) u_beat_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (accept | last_hs),
        .en_i      (beat_hs & ~narrow_last_o),
        .cnt_o     (cnt),
        .at_last_o (at_last)
    );

`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    assign sel = CW'(RATIO - 1) - cnt;
`else
    assign sel = cnt;
`endif

    // Slice mux from the registered buffer only; zero when no word is held.
    always_comb begin
        narrow_data_o = '0;
        if (busy) begin
            for (int i = 0; i < RATIO; i++) begin
                if (sel == CW'(i)) begin
                    narrow_data_o = buf_q[i*NARROW_W +: NARROW_W];
                end
            end
        end
    end

    if (RATIO < 2) begin : g_bad_ratio
        $error("stream_serializer: RATIO must be >= 2");
    end
    if (NARROW_W < 1) begin : g_bad_width
        $error("stream_serializer: NARROW_W must be >= 1");
    end

    // A stalled beat keeps valid, data and last until it is taken.
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (narrow_valid_o && !narrow_ready_i) |=>
            (narrow_valid_o && $stable(narrow_data_o) && $stable(narrow_last_o)))
        else $error("stream_serializer: beat changed under stall");

endmodule
